// File: rtl/xrs_chain.sv
// xrs_chain: cascaded valid/ready register slices with
// synchronous flush and occupancy count.
module xrs_chain #(
  parameter int D_WIDTH = 16,
  parameter int STAGES  = 2,
  parameter int MODE    = 2,
  parameter int LVL_W   = $clog2(2*STAGES+1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               vldi,
  output logic               rdyi,
  input  logic [D_WIDTH-1:0] datai,
  output logic               vldo,
  input  logic               rdyo,
  output logic [D_WIDTH-1:0] datao,
  output logic [LVL_W-1:0]   level
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} st_e;

  if (MODE == 0) begin : g_pass
    assign vldo  = vldi;
    assign datao = datai;
    assign rdyi  = rdyo;
    assign level = '0;
  end else begin : g_reg
    localparam int LMAX = (MODE == 2) ? 2*STAGES : STAGES;

    logic               alive, in_v, out_r;
    logic               rdy0, last_v, in_x, out_x;
    logic [D_WIDTH-1:0] last_d;
    logic [LVL_W-1:0]   lvl;

    assign in_v  = vldi & alive & ~flush;
    assign out_r = rdyo & ~flush;
    assign rdyi  = alive & ~flush & rdy0;
    assign vldo  = last_v & ~flush;
    assign datao = last_d;
    assign level = lvl;
    assign in_x  = vldi & rdyi;
    assign out_x = vldo & rdyo;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) alive <= 1'b0;
      else       alive <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                lvl <= '0;
      else if (flush)           lvl <= '0;
      else if (in_x && !out_x)  lvl <= lvl + LVL_W'(1);
      else if (out_x && !in_x)  lvl <= lvl - LVL_W'(1);
    end

    if (MODE == 1) begin : g_fwd
      logic [STAGES-1:0]  full;
      logic [STAGES:0]    sr, vx;
      logic [D_WIDTH-1:0] q  [STAGES];
      logic [D_WIDTH-1:0] dx [STAGES+1];

      assign vx = {full, in_v};

      // ready ripples back combinationally from rdyo
      always_comb begin
        sr = '0;
        sr[STAGES] = out_r;
        for (int i = STAGES-1; i >= 0; i--)
          sr[i] = ~full[i] | sr[i+1];
      end

      always_comb begin
        dx[0] = datai;
        for (int i = 0; i < STAGES; i++)
          dx[i+1] = q[i];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          full <= '0;
          for (int i = 0; i < STAGES; i++)
            q[i] <= '0;
        end else if (flush) begin
          full <= '0;
        end else begin
          for (int i = 0; i < STAGES; i++)
            if (sr[i]) begin
              full[i] <= vx[i];
              if (vx[i]) q[i] <= dx[i];
            end
        end
      end

      assign rdy0   = sr[0];
      assign last_v = vx[STAGES];
      assign last_d = dx[STAGES];
    end else begin : g_full
      st_e                st   [STAGES];
      st_e                st_n [STAGES];
      logic [STAGES-1:0]  rq, vq, push, pop;
      logic [STAGES-1:0]  ld_o, ld_s, o_sk;
      logic [STAGES:0]    vx, rx;
      logic [D_WIDTH-1:0] oreg [STAGES];
      logic [D_WIDTH-1:0] sreg [STAGES];
      logic [D_WIDTH-1:0] dx   [STAGES+1];

      always_comb begin
        vq = '0;
        dx[0] = datai;
        for (int i = 0; i < STAGES; i++) begin
          vq[i]   = (st[i] != EMPTY);
          dx[i+1] = oreg[i];
        end
      end

      assign vx   = {vq, in_v};
      assign rx   = {out_r, rq};
      assign push = vx[STAGES-1:0] & rq;
      assign pop  = vq & rx[STAGES:1];

      always_comb begin
        ld_o = '0;
        ld_s = '0;
        o_sk = '0;
        for (int i = 0; i < STAGES; i++) begin
          st_n[i] = st[i];
          unique case (st[i])
            EMPTY:
              if (push[i]) begin
                st_n[i] = ONE;
                ld_o[i] = 1'b1;
              end
            ONE:
              if (push[i] && pop[i]) begin
                ld_o[i] = 1'b1;
              end else if (push[i]) begin
                st_n[i] = TWO;
                ld_s[i] = 1'b1;
              end else if (pop[i]) begin
                st_n[i] = EMPTY;
              end
            TWO:
              if (pop[i]) begin
                st_n[i] = ONE;
                ld_o[i] = 1'b1;
                o_sk[i] = 1'b1;
              end
            default: st_n[i] = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rq <= '1;
          for (int i = 0; i < STAGES; i++) begin
            st[i]   <= EMPTY;
            oreg[i] <= '0;
            sreg[i] <= '0;
          end
        end else if (flush) begin
          rq <= '1;
          for (int i = 0; i < STAGES; i++)
            st[i] <= EMPTY;
        end else begin
          for (int i = 0; i < STAGES; i++) begin
            st[i] <= st_n[i];
            rq[i] <= (st_n[i] != TWO);
            if (ld_o[i]) oreg[i] <= o_sk[i] ? sreg[i] : dx[i];
            if (ld_s[i]) sreg[i] <= dx[i];
          end
        end
      end

      assign rdy0   = rx[0];
      assign last_v = vx[STAGES];
      assign last_d = dx[STAGES];
    end

    a_lvl: assert property (@(posedge clk) disable iff (!rstn)
      lvl <= LVL_W'(LMAX));

    a_hold: assert property (@(posedge clk) disable iff (!rstn)
      (vldo && !rdyo) |=> (flush || (vldo && $stable(datao))));
  end

endmodule

// File: tb/tb_xrs_chain.sv
// tb_xrs_chain: directed checks of xrs_chain in modes 0, 1 and 2.
module tb_xrs_chain;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        f2 = 0, v2 = 0, ro2 = 0, r2, vo2;
  logic [15:0] d2 = '0, q2;
  logic [2:0]  l2;

  logic        f1 = 0, v1 = 0, ro1 = 0, r1, vo1;
  logic [15:0] d1 = '0, q1;
  logic [2:0]  l1;

  logic        f0 = 0, v0 = 0, ro0 = 0, r0, vo0;
  logic [15:0] d0 = '0, q0;
  logic [2:0]  l0;

  xrs_chain #(.D_WIDTH(16), .STAGES(2), .MODE(2)) u_m2 (
    .clk(clk), .rstn(rstn), .flush(f2), .vldi(v2), .rdyi(r2),
    .datai(d2), .vldo(vo2), .rdyo(ro2), .datao(q2), .level(l2));

  xrs_chain #(.D_WIDTH(16), .STAGES(3), .MODE(1)) u_m1 (
    .clk(clk), .rstn(rstn), .flush(f1), .vldi(v1), .rdyi(r1),
    .datai(d1), .vldo(vo1), .rdyo(ro1), .datao(q1), .level(l1));

  xrs_chain #(.D_WIDTH(16), .STAGES(2), .MODE(0)) u_m0 (
    .clk(clk), .rstn(rstn), .flush(f0), .vldi(v0), .rdyi(r0),
    .datai(d0), .vldo(vo0), .rdyo(ro0), .datao(q0), .level(l0));

  int n_chk  = 0;
  int n_pass = 0;
  int acc, n;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();

    v0 = 1; d0 = 16'h1234; ro0 = 0; #1;
    check("m0_vldo", vo0, 1);
    check("m0_data", q0, 16'h1234);
    check("m0_rdyi_lo", r0, 0);
    check("m0_level", l0, 0);
    ro0 = 1; #1;
    check("m0_rdyi_in_rst", r0, 1);

    check("rst_rdyi", r2, 0);
    check("rst_vldo", vo2, 0);
    check("rst_datao", q2, 0);
    check("rst_level", l2, 0);

    tick();
    rstn = 1; #1;
    check("rel_rdyi", r2, 0);
    check("rel_vldo", vo2, 0);
    tick();
    check("alive_rdyi", r2, 1);
    check("alive_vldo", vo2, 0);
    check("alive_level", l2, 0);
    check("alive_m1_rdyi", r1, 1);

    // streaming, mode 2
    ro2 = 1;
    for (int c = 0; c < 20; c++) begin
      v2 = (c < 16);
      d2 = 16'(c + 1);
      #1;
      if (c < 16) check("st_rdyi", r2, 1);
      check("st_vldo", vo2, (c >= 2 && c < 18));
      if (c >= 2 && c < 18) check("st_data", q2, 32'(c - 1));
      if (c == 10) check("st_level", l2, 2);
      tick();
    end
    check("st_level_end", l2, 0);

    // backpressure fill and drain, mode 2
    ro2 = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      v2 = 1;
      d2 = 16'hA000 + 16'(acc);
      #1;
      if (r2) acc++;
      tick();
    end
    v2 = 0;
    check("bp_accepted", acc, 4);
    check("bp_rdyi", r2, 0);
    check("bp_level", l2, 4);
    check("bp_vldo", vo2, 1);
    check("bp_head", q2, 16'hA000);
    ro2 = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("bp_vld", vo2, 1);
      check("bp_data", q2, 32'h0000_A000 + 32'(j));
      if (j == 1) check("bp_rdyi_lo", r2, 0);
      if (j == 2) check("bp_rdyi_back", r2, 1);
      tick();
    end
    check("bp_empty", vo2, 0);
    check("bp_level0", l2, 0);

    // mode 1 fill then one-in-one-out
    ro1 = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      v1 = 1;
      d1 = 16'hB000 + 16'(acc);
      #1;
      if (r1) acc++;
      tick();
    end
    check("m1_accepted", acc, 3);
    check("m1_level", l1, 3);
    check("m1_rdyi_full", r1, 0);
    ro1 = 1; #1;
    check("m1_comb_rdyi", r1, 1);
    for (int j = 0; j < 4; j++) begin
      d1 = 16'hB003 + 16'(j);
      #1;
      check("m1_rdyi", r1, 1);
      check("m1_data", q1, 32'h0000_B000 + 32'(j));
      tick();
    end
    check("m1_level_ss", l1, 3);
    v1 = 0; ro1 = 0;

    // flush
    f1 = 1; #1;
    check("fl_mask_vldo0", vo1, 0);
    tick();
    f1 = 0; #1;
    check("fl_clear_level", l1, 0);
    check("fl_clear_vldo", vo1, 0);
    v1 = 1; d1 = 16'h11; tick();
    d1 = 16'h22; tick();
    d1 = 16'h33; tick();
    v1 = 0; #1;
    check("fl_level3", l1, 3);
    check("fl_head", q1, 16'h11);
    v1 = 1; d1 = 16'h99; ro1 = 1; f1 = 1; #1;
    check("fl_rdyi", r1, 0);
    check("fl_vldo", vo1, 0);
    tick();
    f1 = 0; v1 = 0; #1;
    check("fl_level0", l1, 0);
    check("fl_vldo_after", vo1, 0);
    v1 = 1; d1 = 16'h44; #1;
    check("fl_push_rdyi", r1, 1);
    tick();
    v1 = 0;
    n = 0;
    while (!vo1 && n < 10) begin
      tick();
      n++;
    end
    check("fl_first_vld", vo1, 1);
    check("fl_first_data", q1, 16'h44);

    // asynchronous reset mid-stream, mode 2
    ro2 = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      v2 = 1;
      d2 = 16'hC000 + 16'(acc);
      #1;
      if (r2) acc++;
      tick();
    end
    v2 = 0;
    check("ar_accepted", acc, 4);
    check("ar_level", l2, 4);
    check("ar_vldo", vo2, 1);
    #2;
    rstn = 0; #1;
    check("ar_vldo0", vo2, 0);
    check("ar_level0", l2, 0);
    check("ar_datao0", q2, 0);
    check("ar_rdyi0", r2, 0);
    tick();
    rstn = 1;
    tick();
    ro2 = 1; v2 = 1; d2 = 16'h55; #1;
    check("ar_rdyi", r2, 1);
    tick();
    v2 = 0;
    n = 0;
    while (!vo2 && n < 10) begin
      tick();
      n++;
    end
    check("ar_first_vld", vo2, 1);
    check("ar_first_data", q2, 16'h55);
    tick();
    check("ar_drained", vo2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
